// File: rtl/rf_sb.sv
// rf_sb: parametrised GPR file with an in-order load scoreboard reporting RAW (rd_busy) and WAW (ex_cnf).
// Optional feature: define RF_BYPASS_EN for same-cycle forwarding of load returns and execute writes.
module rf_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 16,
  parameter int unsigned NRD   = 3,
  parameter int unsigned NPEND = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic                          ex_we,
  input  logic [$clog2(NREG)-1:0]       ex_idx,
  input  logic [XLEN-1:0]               ex_data,
  output logic                          ex_cnf,
  input  logic                          ld_issue,
  input  logic [$clog2(NREG)-1:0]       ld_idx,
  output logic                          ld_full,
  output logic                          ld_empty,
  input  logic                          ld_rdy,
  input  logic [XLEN-1:0]               ld_data
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = $clog2(NPEND + 1);
  localparam int unsigned PW = (NPEND > 1) ? $clog2(NPEND) : 1;

  logic [XLEN-1:0] gpr_q  [NREG];
  logic [XLEN-1:0] gpr_d  [NREG];
  logic [CW-1:0]   pcnt_q [NREG];
  logic [CW-1:0]   pcnt_d [NREG];
  logic [AW-1:0]   fifo_q [NPEND];
  logic [AW-1:0]   fifo_d [NPEND];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic            run_q;
  logic [AW-1:0]   ridx [NRD];
  logic [AW-1:0]   head_idx;
  logic            ld_acc;
  logic            ld_ret;
  logic            ex_wr;

  // Pointer increment modulo NPEND (NPEND need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NPEND - 1)) ? '0 : p + PW'(1);
  endfunction

  // run_q holds off all writes on the first edge after reset release.
  always_comb begin
    head_idx = fifo_q[head_q];
    ld_full  = (occ_q == CW'(NPEND));
    ld_empty = (occ_q == '0);
    ex_cnf   = (pcnt_q[ex_idx] != '0);
    ld_ret   = run_q && ld_rdy && !ld_empty;
    ld_acc   = run_q && ld_issue && (!ld_full || ld_rdy);
    ex_wr    = run_q && ex_we && !ex_cnf;
  end

  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      ridx[k] = rd_idx[k*AW +: AW];
    end
  end

  // Next state: return is applied before issue so a same-register pair nets to zero.
  always_comb begin
    gpr_d  = gpr_q;
    pcnt_d = pcnt_q;
    fifo_d = fifo_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q + CW'(ld_acc) - CW'(ld_ret);
    if (ex_wr) begin
      gpr_d[ex_idx] = ex_data;
    end
    if (ld_ret) begin
      gpr_d[head_idx]  = ld_data;
      pcnt_d[head_idx] = pcnt_d[head_idx] - CW'(1);
      head_d           = ptr_inc(head_q);
    end
    if (ld_acc) begin
      fifo_d[tail_q]  = ld_idx;
      pcnt_d[ld_idx]  = pcnt_d[ld_idx] + CW'(1);
      tail_d          = ptr_inc(tail_q);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_data[k*XLEN +: XLEN] = gpr_q[ridx[k]];
      rd_busy[k]              = (pcnt_q[ridx[k]] != '0);
`ifdef RF_BYPASS_EN
      if (ld_ret && (head_idx == ridx[k])) begin
        rd_data[k*XLEN +: XLEN] = ld_data;
        rd_busy[k] = (pcnt_q[ridx[k]] != CW'(1)) || (ld_acc && (ld_idx == ridx[k]));
      end else if (ex_wr && (ex_idx == ridx[k])) begin
        rd_data[k*XLEN +: XLEN] = ex_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        gpr_q[r]  <= '0;
        pcnt_q[r] <= '0;
      end
      for (int unsigned p = 0; p < NPEND; p++) begin
        fifo_q[p] <= '0;
      end
    end else begin
      run_q  <= 1'b1;
      gpr_q  <= gpr_d;
      pcnt_q <= pcnt_d;
      fifo_q <= fifo_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule
